dbus_arbiter: RTL

- Round-robin arbiter that shares the system address/dbus/wrtEn bus among NREQ bus masters (CPU, DMA, debug loader).
- Sits between the masters and the memory-mapped devices: HEX, LED, switch, key and timer controllers.
- Muxes the granted master's address and wrtEn onto the shared bus.
- Inserts one dead cycle between owners so tristate dbus drivers never overlap.

---
 rtl/arb_pkg.sv | 20 ++
 rtl/rr_picker.sv | 29 ++
 rtl/dbus_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | arb_pkg : shared types and helpers for the dbus_arbiter slice       |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package arb_pkg;

  localparam int NREQ_MAX = 8;
  localparam int IDXW     = $clog2(NREQ_MAX);

  localparam logic [1:0] ARB_IDLE    = 2'd0;
  localparam logic [1:0] ARB_OWNED   = 2'd1;
  localparam logic [1:0] ARB_HANDOFF = 2'd2;

  function automatic logic [NREQ_MAX-1:0] onehot(input logic [IDXW-1:0] idx);
    onehot = NREQ_MAX'(1) << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_picker : combinational round-robin winner search from rr_ptr     |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module rr_picker #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] rr_ptr,
  output logic                    any,
  output logic [$clog2(NREQ)-1:0] winner
);

  localparam int OW = $clog2(NREQ);

  // Scan backwards so the candidate closest to rr_ptr is the last to win.
  always_comb begin
    any    = |req;
    winner = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % NREQ]) begin
        winner = OW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dbus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dbus_arbiter : round-robin owner of the shared addr/dbus/wrtEn bus  |
// | with one dead cycle per handoff. Option macro: ARB_TIMEOUT_EN       |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module dbus_arbiter
  import arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DBITS    = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         lock,
  input  logic [NREQ*DBITS-1:0]   m_addr,
  input  logic [NREQ-1:0]         m_wrtEn,
  output logic [NREQ-1:0]         gnt,
  output logic [DBITS-1:0]        bus_addr,
  output logic                    bus_wrtEn,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] owner
);

  localparam int OW = $clog2(NREQ);

  logic [1:0]      r_state;
  logic [NREQ-1:0] r_gnt;
  logic [OW-1:0]   r_rr_ptr;
  logic [OW-1:0]   r_owner;
  logic            w_any;
  logic [OW-1:0]   w_winner;
  logic [OW-1:0]   w_next_ptr;
  logic            w_release;

  rr_picker #(
    .NREQ (NREQ)
  ) u_picker (
    .req    (req),
    .rr_ptr (r_rr_ptr),
    .any    (w_any),
    .winner (w_winner)
  );

  assign w_next_ptr = (r_owner == OW'(NREQ - 1)) ? '0 : r_owner + OW'(1);

`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD);

  logic [HW-1:0] r_hold_cnt;

  // r_gnt is the owner's one-hot here, so masking it leaves the competitors.
  assign w_release = !req[r_owner] ||
                     ((r_hold_cnt == HW'(MAX_HOLD - 1)) && !lock[r_owner] &&
                      (|(req & ~r_gnt)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold_cnt <= '0;
    end else if (r_state != ARB_OWNED) begin
      r_hold_cnt <= '0;
    end else if (r_hold_cnt != HW'(MAX_HOLD - 1)) begin
      r_hold_cnt <= r_hold_cnt + HW'(1);
    end
  end
`else
  logic w_unused;

  assign w_unused  = ^{lock, 32'(MAX_HOLD)};
  assign w_release = !req[r_owner];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ARB_IDLE;
      r_gnt    <= '0;
      r_rr_ptr <= '0;
      r_owner  <= '0;
    end else begin
      case (r_state)
        ARB_IDLE, ARB_HANDOFF: begin
          if (w_any) begin
            r_gnt   <= NREQ'(onehot(IDXW'(w_winner)));
            r_owner <= w_winner;
            r_state <= ARB_OWNED;
          end else begin
            r_state <= ARB_IDLE;
          end
        end
        ARB_OWNED: begin
          if (w_release) begin
            r_gnt    <= '0;
            r_rr_ptr <= w_next_ptr;
            r_state  <= ARB_HANDOFF;
          end
        end
        default: begin
          r_gnt   <= '0;
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

  // AND-OR mux keyed on the registered grant so reset clears the bus at once.
  always_comb begin
    bus_addr  = '0;
    bus_wrtEn = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_gnt[i]) begin
        bus_addr  = m_addr[i*DBITS +: DBITS];
        bus_wrtEn = m_wrtEn[i];
      end
    end
  end

  assign gnt   = r_gnt;
  assign busy  = |r_gnt;
  assign owner = r_owner;

endmodule
`default_nettype wire
